// File: rtl/torus_array_ctrl.sv
// Torus PE-array run controller.
// Sequences instruction addresses for one run, stages host load data into the
// IO PEs at run start, and captures IO PE store data back for the host at completion.
module torus_array_ctrl #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned SYS_DWIDTH  = 32,
  parameter int unsigned IO_NUM      = 2,
  parameter int unsigned INST_AWIDTH = 10,
  parameter int unsigned PIPE_DEPTH  = 2
) (
  input  logic                         Clk,
  input  logic                         Resetn,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic                         Stall,
  input  logic [INST_AWIDTH-1:0]       Run_Len,
  input  logic [IO_NUM*SYS_DWIDTH-1:0] Sys_Load,
  input  logic [IO_NUM*DWIDTH-1:0]     Data_Store,
  output logic [IO_NUM*DWIDTH-1:0]     Data_Load,
  output logic [IO_NUM*SYS_DWIDTH-1:0] Sys_Store,
  output logic                         PE_Array_Busy,
  output logic [INST_AWIDTH-1:0]       Inst_Addr,
  output logic                         Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Drain counter value on the final DRAIN cycle; unused when PIPE_DEPTH is 0.
  localparam logic [3:0] DRAIN_LAST = 4'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  state_e                         state_q, state_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [INST_AWIDTH-1:0]         inst_addr_q, inst_addr_d;
  logic [INST_AWIDTH-1:0]         run_len_q, run_len_d;
  logic [3:0]                     drain_cnt_q, drain_cnt_d;
  logic [IO_NUM*DWIDTH-1:0]       data_load_q, data_load_d;
  logic [IO_NUM*SYS_DWIDTH-1:0]   sys_store_q, sys_store_d;

  logic [IO_NUM*DWIDTH-1:0]       load_conv;
  logic [IO_NUM*SYS_DWIDTH-1:0]   store_conv;

  // Host-to-PE channel resize: zero-extend when widening, keep LSBs when narrowing.
  always_comb begin
    load_conv = '0;
    for (int unsigned k = 0; k < IO_NUM; k++) begin
      load_conv[k*DWIDTH +: DWIDTH] = DWIDTH'(Sys_Load[k*SYS_DWIDTH +: SYS_DWIDTH]);
    end
  end

  // PE-to-host channel resize, same rule in the opposite direction.
  always_comb begin
    store_conv = '0;
    for (int unsigned k = 0; k < IO_NUM; k++) begin
      store_conv[k*SYS_DWIDTH +: SYS_DWIDTH] = SYS_DWIDTH'(Data_Store[k*DWIDTH +: DWIDTH]);
    end
  end

  // Next-state and next-output logic; Abort wins over Stall and over completion.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    inst_addr_d = inst_addr_q;
    run_len_d   = run_len_q;
    drain_cnt_d = drain_cnt_q;
    data_load_d = data_load_q;
    sys_store_d = sys_store_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d     = S_RUN;
          busy_d      = 1'b1;
          inst_addr_d = '0;
          run_len_d   = Run_Len;
          drain_cnt_d = '0;
          data_load_d = load_conv;
        end
      end

      S_RUN: begin
        if (Abort) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          drain_cnt_d = '0;
        end else if (!Stall) begin
          if (inst_addr_q == run_len_q) begin
            if (PIPE_DEPTH == 0) begin
              state_d     = S_DONE;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              sys_store_d = store_conv;
            end else begin
              state_d     = S_DRAIN;
              drain_cnt_d = '0;
            end
          end else begin
            inst_addr_d = inst_addr_q + INST_AWIDTH'(1);
          end
        end
      end

      S_DRAIN: begin
        if (Abort) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          drain_cnt_d = '0;
          sys_store_d = store_conv;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs, asynchronously cleared.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inst_addr_q <= '0;
      run_len_q   <= '0;
      drain_cnt_q <= '0;
      data_load_q <= '0;
      sys_store_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      inst_addr_q <= inst_addr_d;
      run_len_q   <= run_len_d;
      drain_cnt_q <= drain_cnt_d;
      data_load_q <= data_load_d;
      sys_store_q <= sys_store_d;
    end
  end

  assign Data_Load     = data_load_q;
  assign Sys_Store     = sys_store_q;
  assign PE_Array_Busy = busy_q;
  assign Inst_Addr     = inst_addr_q;
  assign Done          = done_q;

endmodule

// File: tb/tb_torus_array_ctrl.sv
// Self-checking bench for torus_array_ctrl: default instance plus a
// PIPE_DEPTH=0 instance with unequal PE/host widths.
module tb_torus_array_ctrl;

  localparam int TB_PD = 2;

  logic        Clk;
  logic        Resetn;
  logic        Start;
  logic        Abort;
  logic        Stall;
  logic [9:0]  Run_Len;
  logic [63:0] Sys_Load;
  logic [63:0] Data_Store;
  logic [63:0] Data_Load;
  logic [63:0] Sys_Store;
  logic        PE_Array_Busy;
  logic [9:0]  Inst_Addr;
  logic        Done;

  logic        Start0;
  logic [9:0]  Run_Len0;
  logic [47:0] Sys_Load0;
  logic [31:0] Data_Store0;
  logic [31:0] Data_Load0;
  logic [47:0] Sys_Store0;
  logic        Busy0;
  logic [9:0]  Addr0;
  logic        Done0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  run_len;
    logic [63:0] sys_load;
    logic [63:0] data_store;
    int          stall_at;
    int          stall_len;
    bit          drain_stall;
    int          exp_busy;
  } vec_t;

  typedef struct {
    int          busy;
    logic [9:0]  addr;
    logic [63:0] dload;
    logic [63:0] sstore;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  torus_array_ctrl u_dut (
    .Clk          (Clk),
    .Resetn       (Resetn),
    .Start        (Start),
    .Abort        (Abort),
    .Stall        (Stall),
    .Run_Len      (Run_Len),
    .Sys_Load     (Sys_Load),
    .Data_Store   (Data_Store),
    .Data_Load    (Data_Load),
    .Sys_Store    (Sys_Store),
    .PE_Array_Busy(PE_Array_Busy),
    .Inst_Addr    (Inst_Addr),
    .Done         (Done)
  );

  torus_array_ctrl #(
    .DWIDTH     (16),
    .SYS_DWIDTH (24),
    .IO_NUM     (2),
    .INST_AWIDTH(10),
    .PIPE_DEPTH (0)
  ) u_dut0 (
    .Clk          (Clk),
    .Resetn       (Resetn),
    .Start        (Start0),
    .Abort        (Abort),
    .Stall        (Stall),
    .Run_Len      (Run_Len0),
    .Sys_Load     (Sys_Load0),
    .Data_Store   (Data_Store0),
    .Data_Load    (Data_Load0),
    .Sys_Store    (Sys_Store0),
    .PE_Array_Busy(Busy0),
    .Inst_Addr    (Addr0),
    .Done         (Done0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one run on the default instance; model address/drain progress from
  // the stimulus and compare against the scoreboard entry when Done arrives.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t       e;
    int         busy_n     = 0;
    int         stall_left = 0;
    int         drain_cyc  = 0;
    logic [9:0] exp_addr   = '0;
    bit         in_drain   = 0;
    bit         stall_used = 0;
    bit         got_done   = 0;
    e.busy   = v.exp_busy;
    e.addr   = v.run_len;
    e.dload  = v.sys_load;
    e.sstore = v.data_store;
    sb_q.push_back(e);
    Run_Len    = v.run_len;
    Sys_Load   = v.sys_load;
    Data_Store = ~v.data_store;
    Start      = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 1200 && !got_done; c++) begin
      if (Done) begin
        got_done = 1;
        chk($sformatf("v%0d_sb_depth", idx), 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d_busy_cycles", idx), 64'(busy_n), 64'(e.busy));
          chk($sformatf("v%0d_busy_at_done", idx), 64'(PE_Array_Busy), 64'd0);
          chk($sformatf("v%0d_addr_held", idx), 64'(Inst_Addr), 64'(e.addr));
          chk($sformatf("v%0d_data_load", idx), Data_Load, e.dload);
          chk($sformatf("v%0d_sys_store", idx), Sys_Store, e.sstore);
        end
      end else begin
        if (PE_Array_Busy) begin
          busy_n++;
          chk($sformatf("v%0d_addr_c%0d", idx, c), 64'(Inst_Addr), 64'(exp_addr));
        end
        if (in_drain) drain_cyc++;
        Data_Store = (in_drain && drain_cyc == TB_PD) ? v.data_store : ~v.data_store;
        if (!in_drain && !stall_used && v.stall_len > 0 && exp_addr == 10'(v.stall_at)) begin
          stall_left = v.stall_len;
          stall_used = 1;
        end
        Stall = (stall_left > 0) || (in_drain && v.drain_stall);
        if (stall_left > 0) stall_left--;
        if (!in_drain && !Stall) begin
          if (exp_addr == v.run_len) in_drain = 1;
          else exp_addr++;
        end
        tick();
      end
    end
    Stall = 1'b0;
    if (!got_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d_timeout: Done=0 after 1200 cycles, required Done=1", idx);
      sb_q.delete();
    end
    Data_Store = v.data_store ^ 64'h5A5A_5A5A_5A5A_5A5A;
    tick();
    chk($sformatf("v%0d_done_one_cycle", idx), 64'(Done), 64'd0);
    chk($sformatf("v%0d_busy_idle", idx), 64'(PE_Array_Busy), 64'd0);
    chk($sformatf("v%0d_sys_store_hold", idx), Sys_Store, v.data_store);
  endtask

  initial begin
    bit seen_done;

    vecs[0] = '{10'd3,   64'h0000000B_0000000A, 64'h00000022_00000011, 0, 0, 1'b0, 6};
    vecs[1] = '{10'd3,   64'hDEADBEEF_12345678, 64'hCAFEF00D_0BADC0DE, 1, 2, 1'b0, 8};
    vecs[2] = '{10'd0,   64'hFFFFFFFF_00000000, 64'h00000001_00000002, 0, 0, 1'b0, 3};
    vecs[3] = '{10'd5,   64'h01234567_89ABCDEF, 64'h13579BDF_02468ACE, 0, 0, 1'b1, 8};
    vecs[4] = '{10'd7,   64'hA5A5A5A5_5A5A5A5A, 64'h0F0F0F0F_F0F0F0F0, 0, 1, 1'b0, 11};
    vecs[5] = '{10'h3FF, 64'h80000000_00000001, 64'h7FFFFFFF_FFFFFFFE, 0, 0, 1'b0, 1026};

    Resetn      = 1'b0;
    Start       = 1'b0;
    Abort       = 1'b0;
    Stall       = 1'b0;
    Run_Len     = '0;
    Sys_Load    = '0;
    Data_Store  = '0;
    Start0      = 1'b0;
    Run_Len0    = '0;
    Sys_Load0   = '0;
    Data_Store0 = '0;

    #3;
    chk("rst_busy", 64'(PE_Array_Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_addr", 64'(Inst_Addr), 64'd0);
    chk("rst_data_load", Data_Load, 64'd0);
    chk("rst_sys_store", Sys_Store, 64'd0);
    chk("rst_busy0", 64'(Busy0), 64'd0);
    tick();
    tick();
    Resetn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Re-establish a known Sys_Store, then abort a run at address 2.
    run_vec(vecs[0], 10);
    Run_Len    = 10'd5;
    Data_Store = 64'hEEEEEEEE_EEEEEEEE;
    Start      = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 10 && Inst_Addr != 10'd2; c++) tick();
    chk("abort_reach_addr2", 64'(Inst_Addr), 64'd2);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_run_busy", 64'(PE_Array_Busy), 64'd0);
    chk("abort_run_done", 64'(Done), 64'd0);
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (Done || PE_Array_Busy) seen_done = 1;
    end
    chk("abort_run_no_done", 64'(seen_done), 64'd0);
    chk("abort_run_sys_store", Sys_Store, 64'h00000022_00000011);

    // Abort together with Start in IDLE is ignored; held into RUN it aborts.
    Run_Len = 10'd4;
    Start   = 1'b1;
    Abort   = 1'b1;
    tick();
    Start = 1'b0;
    chk("abort_idle_start_taken", 64'(PE_Array_Busy), 64'd1);
    tick();
    Abort = 1'b0;
    chk("abort_addr0_busy", 64'(PE_Array_Busy), 64'd0);
    chk("abort_addr0_done", 64'(Done), 64'd0);

    // Abort during DRAIN.
    Run_Len = 10'd0;
    Start   = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("abort_drain_busy_before", 64'(PE_Array_Busy), 64'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_drain_busy", 64'(PE_Array_Busy), 64'd0);
    seen_done = Done;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (Done) seen_done = 1;
    end
    chk("abort_drain_no_done", 64'(seen_done), 64'd0);
    chk("abort_drain_sys_store", Sys_Store, 64'h00000022_00000011);

    // PIPE_DEPTH=0 instance, Run_Len=0, Start held through RUN and DONE.
    Sys_Load0   = 48'hABCDEF_123456;
    Data_Store0 = 32'h8001_7FFE;
    Run_Len0    = 10'd0;
    Start0      = 1'b1;
    tick();
    chk("p0_busy", 64'(Busy0), 64'd1);
    chk("p0_addr", 64'(Addr0), 64'd0);
    chk("p0_data_load_trunc", 64'(Data_Load0), 64'h0000_0000_CDEF_3456);
    chk("p0_done_during_busy", 64'(Done0), 64'd0);
    tick();
    chk("p0_busy_fall", 64'(Busy0), 64'd0);
    chk("p0_done", 64'(Done0), 64'd1);
    chk("p0_sys_store_zext", 64'(Sys_Store0), 64'h0000_0080_0100_7FFE);
    tick();
    chk("p0_start_in_done_ignored", 64'(Busy0), 64'd0);
    chk("p0_done_single", 64'(Done0), 64'd0);
    Start0 = 1'b0;
    tick();
    chk("p0_single_run", 64'(Busy0), 64'd0);

    // Reset in the middle of DRAIN.
    Run_Len  = 10'd1;
    Sys_Load = 64'h0000000B_0000000A;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    chk("mid_rst_in_drain", 64'(PE_Array_Busy), 64'd1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(PE_Array_Busy), 64'd0);
    chk("mid_rst_done", 64'(Done), 64'd0);
    chk("mid_rst_addr", 64'(Inst_Addr), 64'd0);
    chk("mid_rst_data_load", Data_Load, 64'd0);
    chk("mid_rst_sys_store", Sys_Store, 64'd0);
    Resetn = 1'b1;
    tick();
    run_vec(vecs[0], 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
